// File: rtl/arp_pkg.sv
// rtl/arp_pkg.sv - shared types, constants and helpers for the ARP controller
package arp_pkg;

   localparam logic [31:0] LOCAL_IP_DEF    = 32'hC0A8_0132;
   localparam int          ARP_PAYLOAD_LEN = 28;

   typedef struct packed {
      logic        valid;
      logic [31:0] ip;
      logic [47:0] mac;
   } cache_entry_t;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_DEC   = 2'd1,
      R_LEARN = 2'd2
   } rx_state_t;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_REQ  = 2'd1,
      T_RST  = 2'd2,
      T_SEND = 2'd3
   } tx_state_t;

   // Adds 0..3 events to a 16-bit counter, sticking at all-ones.
   function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
      logic [16:0] s;
      s = {1'b0, v} + {15'd0, inc};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/arp_cache.sv
// rtl/arp_cache.sv - small IP->MAC cache with round-robin victim and registered lookup
module arp_cache
   import arp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_ip,
   input  logic [47:0] wr_mac,
   input  logic [31:0] lookup_ip,
   output logic        lookup_hit,
   output logic [47:0] lookup_mac
);

   localparam int PW = $clog2(DEPTH);

   cache_entry_t [DEPTH-1:0] ent_q, ent_d;
   logic [PW-1:0]            victim_q, victim_d;
   logic [PW-1:0]            wr_idx;
   logic                     wr_hit;
   logic                     hit_q, hit_d;
   logic [47:0]              mac_q, mac_d;

   // Write path: refresh an existing IP in place, otherwise replace the victim and advance it.
   always_comb begin
      ent_d    = ent_q;
      victim_d = victim_q;
      wr_hit   = 1'b0;
      wr_idx   = victim_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].valid && ent_q[i].ip == wr_ip) begin
            wr_hit = 1'b1;
            wr_idx = PW'(i);
         end
      end
      if (wr_en) begin
         ent_d[wr_idx] = {1'b1, wr_ip, wr_mac};
         if (!wr_hit) begin
            victim_d = victim_q + 1'b1;
         end
      end
   end

   // Lookup path: sees only entries already committed, so a same-cycle write shows up next cycle.
   always_comb begin
      hit_d = 1'b0;
      mac_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].valid && ent_q[i].ip == lookup_ip) begin
            hit_d = 1'b1;
            mac_d = ent_q[i].mac;
         end
      end
   end

   // Entry storage, victim pointer and lookup result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ent_q    <= '0;
         victim_q <= '0;
         hit_q    <= 1'b0;
         mac_q    <= '0;
      end else begin
         ent_q    <= ent_d;
         victim_q <= victim_d;
         hit_q    <= hit_d;
         mac_q    <= mac_d;
      end
   end

   assign lookup_hit = hit_q;
   assign lookup_mac = mac_q;

endmodule

// File: rtl/arp_ctrl.sv
// rtl/arp_ctrl.sv - ARP RX learn / TX reply sequencer around the decoder and encoder
module arp_ctrl
   import arp_pkg::*;
#(
   parameter logic [31:0] LOCAL_IP    = LOCAL_IP_DEF,
   parameter int          CACHE_DEPTH = 4,
   parameter int          TX_TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arp_start,
   output logic        dec_rst,
   input  logic        dec_done,
   input  logic        dec_err,
   input  logic [47:0] dec_sha,
   input  logic [31:0] dec_spa,
   input  logic [31:0] dec_tpa,
   output logic        enc_rst,
   output logic        enc_en,
   output logic [47:0] enc_tha,
   output logic [31:0] enc_tpa,
   input  logic        enc_ovalid,
   output logic        tx_req,
   input  logic        tx_gnt,
   output logic        tx_done,
   input  logic [31:0] lookup_ip,
   output logic        lookup_hit,
   output logic [47:0] lookup_mac,
   output logic [15:0] drop_cnt,
   output logic [15:0] err_cnt
);

   localparam logic [15:0] TMO_LAST = 16'(TX_TIMEOUT - 1);

   rx_state_t   rx_q, rx_d;
   tx_state_t   tx_q, tx_d;
   logic [47:0] sha_q, sha_d;
   logic [31:0] spa_q, spa_d, tpa_q, tpa_d;
   logic        pend_v_q, pend_v_d;
   logic [47:0] pend_mac_q, pend_mac_d;
   logic [31:0] pend_ip_q, pend_ip_d;
   logic [47:0] act_mac_q, act_mac_d;
   logic [31:0] act_ip_q, act_ip_d;
   logic [47:0] tha_q, tha_d;
   logic [31:0] etpa_q, etpa_d;
   logic [15:0] tmo_q, tmo_d;
   logic        seen_q, seen_d;
   logic [15:0] drop_q, drop_d, err_q, err_d;
   logic        learn_wr, learn_local, err_inc;
   logic        pend_take, tmo_abort, done_c, drop_full;

   // RX sequencing: decode a frame, latch its addresses, then spend one cycle learning.
   always_comb begin
      rx_d        = rx_q;
      sha_d       = sha_q;
      spa_d       = spa_q;
      tpa_d       = tpa_q;
      learn_wr    = 1'b0;
      learn_local = 1'b0;
      err_inc     = 1'b0;
      case (rx_q)
         R_IDLE: begin
            if (arp_start) rx_d = R_DEC;
         end
         R_DEC: begin
            if (arp_start) begin
               rx_d = R_DEC;
            end else if (dec_err) begin
               err_inc = 1'b1;
               rx_d    = R_IDLE;
            end else if (dec_done) begin
               sha_d = dec_sha;
               spa_d = dec_spa;
               tpa_d = dec_tpa;
               rx_d  = R_LEARN;
            end
         end
         R_LEARN: begin
            learn_wr    = 1'b1;
            learn_local = (tpa_q == LOCAL_IP);
            rx_d        = arp_start ? R_DEC : R_IDLE;
         end
         default: rx_d = R_IDLE;
      endcase
   end

   // TX sequencing: take the pending reply, win the line, reset then run the encoder.
   always_comb begin
      tx_d      = tx_q;
      act_mac_d = act_mac_q;
      act_ip_d  = act_ip_q;
      tha_d     = tha_q;
      etpa_d    = etpa_q;
      tmo_d     = tmo_q;
      seen_d    = seen_q;
      pend_take = 1'b0;
      tmo_abort = 1'b0;
      done_c    = 1'b0;
      case (tx_q)
         T_IDLE: begin
            if (pend_v_q) begin
               pend_take = 1'b1;
               act_mac_d = pend_mac_q;
               act_ip_d  = pend_ip_q;
               tx_d      = T_REQ;
            end
         end
         T_REQ: begin
            if (tx_gnt) tx_d = T_RST;
         end
         T_RST: begin
            tha_d  = act_mac_q;
            etpa_d = act_ip_q;
            tmo_d  = '0;
            seen_d = 1'b0;
            tx_d   = T_SEND;
         end
         T_SEND: begin
            tmo_d = tmo_q + 16'd1;
            if (enc_ovalid) seen_d = 1'b1;
            if (seen_q && !enc_ovalid) begin
               done_c = 1'b1;
               tx_d   = T_IDLE;
            end else if (tmo_q == TMO_LAST) begin
               tmo_abort = 1'b1;
               tx_d      = T_IDLE;
            end
         end
         default: tx_d = T_IDLE;
      endcase
   end

   // Pending slot and counters; a take and a load in the same cycle never drops.
   always_comb begin
      pend_v_d   = pend_v_q;
      pend_mac_d = pend_mac_q;
      pend_ip_d  = pend_ip_q;
      drop_full  = 1'b0;
      if (pend_take) pend_v_d = 1'b0;
      if (learn_local) begin
         if (pend_v_d) begin
            drop_full = 1'b1;
         end else begin
            pend_v_d   = 1'b1;
            pend_mac_d = sha_q;
            pend_ip_d  = spa_q;
         end
      end
      drop_d = sat_add16(drop_q, 2'(drop_full) + 2'(tmo_abort));
      err_d  = sat_add16(err_q, 2'(err_inc));
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_q       <= R_IDLE;
         tx_q       <= T_IDLE;
         sha_q      <= '0;
         spa_q      <= '0;
         tpa_q      <= '0;
         pend_v_q   <= 1'b0;
         pend_mac_q <= '0;
         pend_ip_q  <= '0;
         act_mac_q  <= '0;
         act_ip_q   <= '0;
         tha_q      <= '0;
         etpa_q     <= '0;
         tmo_q      <= '0;
         seen_q     <= 1'b0;
         drop_q     <= '0;
         err_q      <= '0;
      end else begin
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         sha_q      <= sha_d;
         spa_q      <= spa_d;
         tpa_q      <= tpa_d;
         pend_v_q   <= pend_v_d;
         pend_mac_q <= pend_mac_d;
         pend_ip_q  <= pend_ip_d;
         act_mac_q  <= act_mac_d;
         act_ip_q   <= act_ip_d;
         tha_q      <= tha_d;
         etpa_q     <= etpa_d;
         tmo_q      <= tmo_d;
         seen_q     <= seen_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
      end
   end

   arp_cache #(.DEPTH(CACHE_DEPTH)) u_cache (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (learn_wr),
      .wr_ip      (spa_q),
      .wr_mac     (sha_q),
      .lookup_ip  (lookup_ip),
      .lookup_hit (lookup_hit),
      .lookup_mac (lookup_mac)
   );

   assign dec_rst  = (rx_q != R_DEC) || arp_start;
   assign enc_rst  = (tx_q != T_SEND);
   assign enc_en   = (tx_q == T_SEND);
   assign tx_req   = (tx_q != T_IDLE);
   assign tx_done  = done_c;
   assign enc_tha  = tha_q;
   assign enc_tpa  = etpa_q;
   assign drop_cnt = drop_q;
   assign err_cnt  = err_q;

endmodule

// File: tb/tb_arp_ctrl.sv
// tb/tb_arp_ctrl.sv - self-checking bench for arp_ctrl
module tb_arp_ctrl;
   import arp_pkg::*;

   localparam logic [31:0] LIP = 32'hC0A8_0132;

   logic        clk = 1'b0;
   logic        rst, arp_start, dec_rst, dec_done, dec_err;
   logic [47:0] dec_sha;
   logic [31:0] dec_spa, dec_tpa;
   logic        enc_rst, enc_en, enc_ovalid, tx_req, tx_gnt, tx_done, lookup_hit;
   logic [47:0] enc_tha, lookup_mac;
   logic [31:0] enc_tpa, lookup_ip;
   logic [15:0] drop_cnt, err_cnt;

   always #5 clk = ~clk;

   arp_ctrl #(.LOCAL_IP(LIP), .CACHE_DEPTH(4), .TX_TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .arp_start(arp_start), .dec_rst(dec_rst),
      .dec_done(dec_done), .dec_err(dec_err), .dec_sha(dec_sha), .dec_spa(dec_spa),
      .dec_tpa(dec_tpa), .enc_rst(enc_rst), .enc_en(enc_en), .enc_tha(enc_tha),
      .enc_tpa(enc_tpa), .enc_ovalid(enc_ovalid), .tx_req(tx_req), .tx_gnt(tx_gnt),
      .tx_done(tx_done), .lookup_ip(lookup_ip), .lookup_hit(lookup_hit),
      .lookup_mac(lookup_mac), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
   );

   int n_vec = 0;
   int n_bad = 0;

   // reference model: 4-entry cache with insertion-order replacement, reply queue, counters
   logic [31:0] m_ip[4];
   logic [47:0] m_mac[4];
   bit          m_v[4];
   int          m_vic, m_err, m_drop;
   logic [79:0] q[$];

   typedef struct {
      logic [47:0] sha;
      logic [31:0] spa;
      bit          err;
      logic [31:0] lip;
      bit          exp_hit;
      logic [47:0] exp_mac;
      int          exp_err;
   } vec_t;

   vec_t tbl[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < 4; i++) begin
         m_v[i] = 0; m_ip[i] = '0; m_mac[i] = '0;
      end
      m_vic = 0; m_err = 0; m_drop = 0;
      q.delete();
   endfunction

   function automatic void m_learn(input logic [31:0] ip, input logic [47:0] mac);
      for (int i = 0; i < 4; i++) begin
         if (m_v[i] && m_ip[i] == ip) begin
            m_mac[i] = mac;
            return;
         end
      end
      m_v[m_vic] = 1; m_ip[m_vic] = ip; m_mac[m_vic] = mac;
      m_vic = (m_vic + 1) % 4;
   endfunction

   task automatic frame(input logic [47:0] sha, input logic [31:0] spa,
                        input logic [31:0] tpa, input bit err);
      int lat;
      lat = $urandom_range(1, 3);
      arp_start = 1'b1;
      step();
      arp_start = 1'b0;
      #1;
      check("dec_rst_in_dec", 64'(dec_rst), 64'(0));
      for (int i = 1; i < lat; i++) step();
      dec_sha = sha; dec_spa = spa; dec_tpa = tpa;
      dec_err = err; dec_done = !err;
      step();
      dec_err = 1'b0; dec_done = 1'b0;
      step();
      step();
      if (err) begin
         m_err++;
      end else begin
         m_learn(spa, sha);
         if (tpa == LIP) begin
            if (q.size() < 2) q.push_back({sha, spa});
            else m_drop++;
         end
      end
   endtask

   task automatic lookup_chk(input logic [31:0] ip);
      bit          h;
      logic [47:0] m;
      h = 0; m = '0;
      for (int i = 0; i < 4; i++) if (m_v[i] && m_ip[i] == ip) begin h = 1; m = m_mac[i]; end
      lookup_ip = ip;
      step();
      check($sformatf("lookup_hit_%h", ip), 64'(lookup_hit), 64'(h));
      if (h) check($sformatf("lookup_mac_%h", ip), 64'(lookup_mac), 64'(m));
   endtask

   task automatic wait_req_en();
      int n;
      n = 0;
      while (!tx_req && n < 20) begin step(); n++; end
      check("tx_req_up", 64'(tx_req), 64'(1));
      tx_gnt = 1'b1;
      n = 0;
      while (!enc_en && n < 10) begin step(); n++; end
      check("enc_en_up", 64'(enc_en), 64'(1));
   endtask

   task automatic serve(input int gd, input int nb);
      logic [79:0] e;
      int n, rc, dn;
      e = '0;
      if (q.size() > 0) e = q.pop_front();
      n = 0;
      while (!tx_req && n < 20) begin step(); n++; end
      check("tx_req_up", 64'(tx_req), 64'(1));
      rc = 0;
      for (int i = 0; i < gd; i++) begin
         if (tx_req) rc++;
         step();
      end
      if (gd > 0) check("tx_req_hold", 64'(rc), 64'(gd));
      tx_gnt = 1'b1;
      n = 0;
      while (!enc_en && n < 10) begin step(); n++; end
      check("enc_en_up", 64'(enc_en), 64'(1));
      check("enc_rst_low", 64'(enc_rst), 64'(0));
      check("enc_tha", 64'(enc_tha), 64'(e[79:32]));
      check("enc_tpa", 64'(enc_tpa), 64'(e[31:0]));
      dn = 0;
      for (int c = 0; c < nb + 8; c++) begin
         enc_ovalid = (c >= 2 && c < nb + 2);
         #1;
         if (tx_done) begin dn++; tx_gnt = 1'b0; end
         if (c == nb) check("enc_tha_hold", 64'(enc_tha), 64'(e[79:32]));
         step();
      end
      enc_ovalid = 1'b0;
      tx_gnt = 1'b0;
      check("tx_done_pulses", 64'(dn), 64'(1));
   endtask

   initial begin
      int n, dn;
      rst = 1'b1; arp_start = 0; dec_done = 0; dec_err = 0;
      dec_sha = '0; dec_spa = '0; dec_tpa = '0;
      enc_ovalid = 0; tx_gnt = 0; lookup_ip = '0;
      m_reset();

      tbl[0] = '{48'h0200_0000_000A, 32'hC0A8_0101, 0, 32'hC0A8_0101, 1, 48'h0200_0000_000A, 0};
      tbl[1] = '{48'h0200_0000_0002, 32'hC0A8_0102, 0, 32'hC0A8_0102, 1, 48'h0200_0000_0002, 0};
      tbl[2] = '{48'h0200_0000_0003, 32'hC0A8_0103, 0, 32'hC0A8_0101, 1, 48'h0200_0000_000A, 0};
      tbl[3] = '{48'h0200_0000_0004, 32'hC0A8_0104, 0, 32'hC0A8_0104, 1, 48'h0200_0000_0004, 0};
      tbl[4] = '{48'h0200_0000_0005, 32'hC0A8_0105, 0, 32'hC0A8_0101, 0, 48'h0, 0};
      tbl[5] = '{48'h0200_0000_0066, 32'hC0A8_0106, 1, 32'hC0A8_0106, 0, 48'h0, 1};
      tbl[6] = '{48'h0200_0000_0022, 32'hC0A8_0102, 0, 32'hC0A8_0102, 1, 48'h0200_0000_0022, 1};
      tbl[7] = '{48'h0200_0000_0006, 32'hC0A8_0106, 0, 32'hC0A8_0102, 0, 48'h0, 1};

      repeat (3) step();
      check("rst_dec_rst", 64'(dec_rst), 64'(1));
      check("rst_enc_rst", 64'(enc_rst), 64'(1));
      check("rst_enc_en", 64'(enc_en), 64'(0));
      check("rst_tx_req", 64'(tx_req), 64'(0));
      check("rst_tx_done", 64'(tx_done), 64'(0));
      check("rst_lookup_hit", 64'(lookup_hit), 64'(0));
      check("rst_lookup_mac", 64'(lookup_mac), 64'(0));
      check("rst_enc_tha", 64'(enc_tha), 64'(0));
      check("rst_enc_tpa", 64'(enc_tpa), 64'(0));
      check("rst_drop", 64'(drop_cnt), 64'(0));
      check("rst_err", 64'(err_cnt), 64'(0));
      rst = 1'b0;
      step();

      // reply to a request for our address, grant after 3 cycles, 28-byte payload
      frame(48'h0200_0000_0001, 32'hC0A8_0101, LIP, 0);
      serve(3, ARP_PAYLOAD_LEN);
      check("t1_tx_req_idle", 64'(tx_req), 64'(0));

      // cache learn / evict / update table
      foreach (tbl[i]) begin
         frame(tbl[i].sha, tbl[i].spa, 32'hC0A8_0199, tbl[i].err);
         check($sformatf("tbl%0d_tx_req", i), 64'(tx_req), 64'(0));
         lookup_ip = tbl[i].lip;
         step();
         check($sformatf("tbl%0d_hit", i), 64'(lookup_hit), 64'(tbl[i].exp_hit));
         if (tbl[i].exp_hit) check($sformatf("tbl%0d_mac", i), 64'(lookup_mac), 64'(tbl[i].exp_mac));
         check($sformatf("tbl%0d_err", i), 64'(err_cnt), 64'(tbl[i].exp_err));
      end
      for (int k = 1; k <= 6; k++) lookup_chk(32'hC0A8_0100 + 32'(k));

      // three requests with the line held off: two held, third dropped, sent in order
      frame(48'h0200_0000_00B1, 32'hC0A8_0201, LIP, 0);
      frame(48'h0200_0000_00B2, 32'hC0A8_0202, LIP, 0);
      frame(48'h0200_0000_00B3, 32'hC0A8_0203, LIP, 0);
      check("hold3_drop", 64'(drop_cnt), 64'(1));
      check("hold3_model_drop", 64'(drop_cnt), 64'(m_drop));
      serve(2, ARP_PAYLOAD_LEN);
      serve(0, 5);
      step();
      check("hold3_tx_req_idle", 64'(tx_req), 64'(0));

      // encoder never produces bytes: abort after the timeout
      frame(48'h0200_0000_00C1, 32'hC0A8_0301, LIP, 0);
      void'(q.pop_front());
      m_drop++;
      wait_req_en();
      n = 0; dn = 0;
      while (enc_en && n < 100) begin
         #1;
         if (tx_done) dn++;
         n++;
         step();
      end
      tx_gnt = 1'b0;
      check("tmo_send_cycles", 64'(n), 64'(64));
      check("tmo_no_done", 64'(dn), 64'(0));
      check("tmo_drop", 64'(drop_cnt), 64'(m_drop));
      check("tmo_err", 64'(err_cnt), 64'(m_err));
      check("tmo_tx_req", 64'(tx_req), 64'(0));

      // reset in the middle of a send
      frame(48'h0200_0000_00D1, 32'hC0A8_0401, LIP, 0);
      wait_req_en();
      enc_ovalid = 1'b1;
      repeat (5) step();
      rst = 1'b1;
      #1;
      check("rstsend_no_done_pre", 64'(tx_done), 64'(0));
      step();
      enc_ovalid = 1'b0; tx_gnt = 1'b0;
      #1;
      check("rstsend_tx_req", 64'(tx_req), 64'(0));
      check("rstsend_enc_en", 64'(enc_en), 64'(0));
      check("rstsend_enc_rst", 64'(enc_rst), 64'(1));
      check("rstsend_dec_rst", 64'(dec_rst), 64'(1));
      check("rstsend_tx_done", 64'(tx_done), 64'(0));
      check("rstsend_tha", 64'(enc_tha), 64'(0));
      check("rstsend_tpa", 64'(enc_tpa), 64'(0));
      check("rstsend_hit", 64'(lookup_hit), 64'(0));
      check("rstsend_drop", 64'(drop_cnt), 64'(0));
      check("rstsend_err", 64'(err_cnt), 64'(0));
      rst = 1'b0;
      m_reset();
      dn = 0;
      for (int i = 0; i < 4; i++) begin
         if (tx_done || tx_req) dn++;
         step();
      end
      check("rstsend_quiet", 64'(dn), 64'(0));
      lookup_chk(32'hC0A8_0101);

      // randomized traffic with the line held off, then drain
      for (int f = 0; f < 40; f++) begin
         logic [31:0] spa, tpa;
         logic [47:0] sha;
         bit err;
         spa = 32'hC0A8_0A00 + 32'($urandom_range(0, 5));
         sha = {16'h0200, 32'($urandom())};
         tpa = ($urandom_range(0, 9) < 3) ? LIP : 32'hC0A8_0A63;
         err = ($urandom_range(0, 9) < 2);
         frame(sha, spa, tpa, err);
         lookup_chk(32'hC0A8_0A00 + 32'($urandom_range(0, 6)));
         check("rand_err", 64'(err_cnt), 64'(m_err));
         check("rand_drop", 64'(drop_cnt), 64'(m_drop));
      end
      n = 0;
      while (q.size() > 0 && n < 4) begin
         serve(1, ARP_PAYLOAD_LEN);
         n++;
      end
      step();
      check("final_tx_req", 64'(tx_req), 64'(0));
      check("final_drop", 64'(drop_cnt), 64'(m_drop));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
